// File: rtl/int_issue_queue_pkg.sv
// Shared definitions for the integer issue queue.
//
// Contents:
//   ISQ_DEPTH, ISQ_PREG_W, ISQ_DATA_W  default sizes for the queue and its payload
//   *_LSB / *_BIT                      field positions inside the dispatch payload
//   ROBID_W                            width of the ROB id field
package int_issue_queue_pkg;

  localparam int unsigned ISQ_DEPTH  = 8;
  localparam int unsigned ISQ_PREG_W = 6;
  localparam int unsigned ISQ_DATA_W = 248;

  // Dispatch payload layout
  localparam int unsigned PRS1_LSB        = 111;
  localparam int unsigned PRS2_LSB        = 105;
  localparam int unsigned SRC1_IS_REG_BIT = 104;
  localparam int unsigned SRC2_IS_REG_BIT = 103;
  localparam int unsigned ROBID_LSB       = 241;
  localparam int unsigned ROBID_W         = 7;

endpackage

// File: rtl/isq_age_matrix.sv
// Age matrix for the integer issue queue.
//
// older_q[i][j] is set when entry j was allocated before entry i and is still live.
// An allocation sets the new entry's row to the set of live entries; a free clears
// the freed entry's column so it stops blocking anyone.
//
// Ports:
//   clock    in   clock
//   reset_n  in   synchronous active-low reset
//   flush    in   clear all age information
//   alloc    in   one-hot entry being allocated this cycle (or zero)
//   free     in   one-hot entry being released this cycle (or zero)
//   valid    in   currently occupied entries
//   req      in   candidate entries for selection
//   oldest   out  one-hot oldest candidate (zero when req is zero)
module isq_age_matrix
  import int_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH = ISQ_DEPTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic [DEPTH-1:0] alloc,
  input  logic [DEPTH-1:0] free,
  input  logic [DEPTH-1:0] valid,
  input  logic [DEPTH-1:0] req,
  output logic [DEPTH-1:0] oldest
);

  logic [DEPTH-1:0] older_q [DEPTH];

  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        older_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (alloc[i]) begin
            // An entry leaving this cycle must not be recorded as older.
            older_q[i][j] <= valid[j] & ~free[j];
          end else if (free[j]) begin
            older_q[i][j] <= 1'b0;
          end
        end
      end
    end
  end

  // A candidate wins when no other candidate is older than it.
  always_comb begin
    oldest = '0;
    for (int i = 0; i < DEPTH; i++) begin
      oldest[i] = req[i] & ~(|(older_q[i] & req));
    end
  end

endmodule

// File: rtl/int_issue_queue.sv
// Integer issue queue between dispatch and the integer execute stage.
//
// Accepts one renamed instruction per cycle, parks it with per-source sleep bits
// until writeback wakeup clears them, and issues the oldest ready entry over a
// valid/ready handshake. A redirect flush empties the queue.
//
// Optional feature macro: ISQ_WAKEUP_BYPASS_EN
//   defined   - a source being written is also awake if its prs matches a
//               same-cycle valid wb0_prd/wb1_prd
//   undefined - sleep bits on write come only from disp2isq_src*_busy
//
// Ports:
//   clock, reset_n            clock and synchronous active-low reset
//   flush                     redirect; drops every entry and any same-cycle write/issue
//   disp2isq_wren/_wrdata     dispatch write request and payload
//   disp2isq_src1/2_busy      busy-table status of prs1/prs2
//   isq2disp_ready            queue has a free entry (from registered count)
//   wb0/1_valid, wb0/1_prd    writeback wakeup ports
//   isq2exu_valid/_data       oldest ready entry and its payload
//   exu2isq_ready             execute accepts the issue
//   isq_count                 occupied entries
module int_issue_queue
  import int_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = ISQ_DEPTH,
  parameter int unsigned DATA_W = ISQ_DATA_W,
  parameter int unsigned PREG_W = ISQ_PREG_W,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              disp2isq_wren,
  input  logic [DATA_W-1:0] disp2isq_wrdata,
  input  logic              disp2isq_src1_busy,
  input  logic              disp2isq_src2_busy,
  output logic              isq2disp_ready,
  input  logic              wb0_valid,
  input  logic [PREG_W-1:0] wb0_prd,
  input  logic              wb1_valid,
  input  logic [PREG_W-1:0] wb1_prd,
  output logic              isq2exu_valid,
  output logic [DATA_W-1:0] isq2exu_data,
  input  logic              exu2isq_ready,
  output logic [CNT_W-1:0]  isq_count
);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  sleep1_q, sleep1_d;
  logic [DEPTH-1:0]  sleep2_q, sleep2_d;
  logic [DATA_W-1:0] payload_q [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;

  logic [DEPTH-1:0]  ready_vec;
  logic [DEPTH-1:0]  sel_oh;
  logic [DEPTH-1:0]  free_slot_oh;
  logic [DEPTH-1:0]  alloc_oh;
  logic [DEPTH-1:0]  free_oh;
  logic [DEPTH-1:0]  wake1, wake2;
  logic              wr_fire, iss_fire;
  logic              new_sleep1, new_sleep2;
  logic              bypass1, bypass2;

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  assign isq2disp_ready = (count_q < CNT_W'(DEPTH));
  assign isq_count      = count_q;

  assign ready_vec     = valid_q & ~sleep1_q & ~sleep2_q;
  assign isq2exu_valid = |ready_vec;

  // Flush discards any same-cycle write or issue.
  assign wr_fire  = disp2isq_wren && isq2disp_ready && !flush;
  assign iss_fire = isq2exu_valid && exu2isq_ready && !flush;

  // ---------------------------------------------------------------------------
  // Allocation: lowest-index free entry. An entry issuing this cycle still has
  // valid_q set, so its slot is only reused from the next cycle on.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic found;
    free_slot_oh = '0;
    found        = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_q[i] && !found) begin
        free_slot_oh[i] = 1'b1;
        found           = 1'b1;
      end
    end
  end

  assign alloc_oh = free_slot_oh & {DEPTH{wr_fire}};
  assign free_oh  = sel_oh & {DEPTH{iss_fire}};

  // ---------------------------------------------------------------------------
  // Initial sleep state of the entry being written
  // ---------------------------------------------------------------------------
`ifdef ISQ_WAKEUP_BYPASS_EN
  logic [PREG_W-1:0] wr_prs1, wr_prs2;

  assign wr_prs1 = disp2isq_wrdata[PRS1_LSB +: PREG_W];
  assign wr_prs2 = disp2isq_wrdata[PRS2_LSB +: PREG_W];

  // Covers a busy-table read that has not yet seen this cycle's writeback.
  assign bypass1 = (wb0_valid && (wr_prs1 == wb0_prd)) || (wb1_valid && (wr_prs1 == wb1_prd));
  assign bypass2 = (wb0_valid && (wr_prs2 == wb0_prd)) || (wb1_valid && (wr_prs2 == wb1_prd));
`else
  assign bypass1 = 1'b0;
  assign bypass2 = 1'b0;
`endif

  assign new_sleep1 = disp2isq_wrdata[SRC1_IS_REG_BIT] && disp2isq_src1_busy && !bypass1;
  assign new_sleep2 = disp2isq_wrdata[SRC2_IS_REG_BIT] && disp2isq_src2_busy && !bypass2;

  // ---------------------------------------------------------------------------
  // Wakeup: both writeback ports compared against every entry in parallel
  // ---------------------------------------------------------------------------
  always_comb begin
    wake1 = '0;
    wake2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wake1[i] = (wb0_valid && (payload_q[i][PRS1_LSB +: PREG_W] == wb0_prd)) ||
                 (wb1_valid && (payload_q[i][PRS1_LSB +: PREG_W] == wb1_prd));
      wake2[i] = (wb0_valid && (payload_q[i][PRS2_LSB +: PREG_W] == wb0_prd)) ||
                 (wb1_valid && (payload_q[i][PRS2_LSB +: PREG_W] == wb1_prd));
    end
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    valid_d  = (valid_q & ~free_oh) | alloc_oh;
    sleep1_d = sleep1_q & ~wake1;
    sleep2_d = sleep2_q & ~wake2;
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc_oh[i]) begin
        sleep1_d[i] = new_sleep1;
        sleep2_d[i] = new_sleep2;
      end
    end
    count_d = count_q + CNT_W'(wr_fire) - CNT_W'(iss_fire);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      valid_q  <= '0;
      sleep1_q <= '0;
      sleep2_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q  <= valid_d;
      sleep1_q <= sleep1_d;
      sleep2_q <= sleep2_d;
      count_q  <= count_d;
    end
  end

  // Payload needs no reset: it is only observed through a valid entry.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc_oh[i]) begin
        payload_q[i] <= disp2isq_wrdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Oldest-ready select
  // ---------------------------------------------------------------------------
  isq_age_matrix #(
    .DEPTH (DEPTH)
  ) u_age_matrix (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (flush),
    .alloc   (alloc_oh),
    .free    (free_oh),
    .valid   (valid_q),
    .req     (ready_vec),
    .oldest  (sel_oh)
  );

  // AND-OR mux; all zeros when nothing is ready.
  always_comb begin
    isq2exu_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      isq2exu_data = isq2exu_data | ({DATA_W{sel_oh[i]}} & payload_q[i]);
    end
  end

endmodule

// File: tb/tb_int_issue_queue.sv
// Self-checking bench for int_issue_queue: a queue-based reference model in
// age order checked every cycle, plus directed scenarios with literal expectations.
module tb_int_issue_queue;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 248;
  localparam int PREG_W = 6;
  localparam int CNT_W  = 4;

  logic              clock;
  logic              reset_n;
  logic              flush;
  logic              disp2isq_wren;
  logic [DATA_W-1:0] disp2isq_wrdata;
  logic              disp2isq_src1_busy;
  logic              disp2isq_src2_busy;
  logic              isq2disp_ready;
  logic              wb0_valid;
  logic [PREG_W-1:0] wb0_prd;
  logic              wb1_valid;
  logic [PREG_W-1:0] wb1_prd;
  logic              isq2exu_valid;
  logic [DATA_W-1:0] isq2exu_data;
  logic              exu2isq_ready;
  logic [CNT_W-1:0]  isq_count;

  int n_cmp  = 0;
  int n_fail = 0;
  bit live   = 0;

  int_issue_queue dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .flush              (flush),
    .disp2isq_wren      (disp2isq_wren),
    .disp2isq_wrdata    (disp2isq_wrdata),
    .disp2isq_src1_busy (disp2isq_src1_busy),
    .disp2isq_src2_busy (disp2isq_src2_busy),
    .isq2disp_ready     (isq2disp_ready),
    .wb0_valid          (wb0_valid),
    .wb0_prd            (wb0_prd),
    .wb1_valid          (wb1_valid),
    .wb1_prd            (wb1_prd),
    .isq2exu_valid      (isq2exu_valid),
    .isq2exu_data       (isq2exu_data),
    .exu2isq_ready      (exu2isq_ready),
    .isq_count          (isq_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk(input int robid, input int prs1, input int prs2,
                                           input bit r1, input bit r2);
    logic [DATA_W-1:0] p;
    p          = '0;
    p[247:241] = 7'(robid);
    p[116:111] = 6'(prs1);
    p[110:105] = 6'(prs2);
    p[104]     = r1;
    p[103]     = r2;
    p[31:0]    = 32'h1234_5600 + 32'(robid);
    return p;
  endfunction

  function automatic logic [6:0] robid_of(input logic [DATA_W-1:0] p);
    return p[247:241];
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: entries kept oldest-first
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [DATA_W-1:0] p;
    bit                s1;
    bit                s2;
  } ment_t;

  ment_t mq[$];

  function automatic bit wb_hit(input logic [PREG_W-1:0] r);
    return (wb0_valid && wb0_prd == r) || (wb1_valid && wb1_prd == r);
  endfunction

  function automatic bit byp(input logic [PREG_W-1:0] r);
`ifdef ISQ_WAKEUP_BYPASS_EN
    return wb_hit(r);
`else
    return (r != r);
`endif
  endfunction

  function automatic int model_sel();
    for (int i = 0; i < mq.size(); i++) begin
      if (!mq[i].s1 && !mq[i].s2) return i;
    end
    return -1;
  endfunction

  always @(posedge clock) begin
    int    sel;
    int    sz;
    ment_t e;
    if (!reset_n) begin
      mq.delete();
      live = 1'b1;
    end else if (flush) begin
      mq.delete();
    end else begin
      sel = model_sel();
      sz  = mq.size();
      for (int i = 0; i < mq.size(); i++) begin
        e = mq[i];
        if (wb_hit(e.p[116:111])) e.s1 = 1'b0;
        if (wb_hit(e.p[110:105])) e.s2 = 1'b0;
        mq[i] = e;
      end
      if (sel >= 0 && exu2isq_ready) mq.delete(sel);
      if (disp2isq_wren && sz < DEPTH) begin
        e.p  = disp2isq_wrdata;
        e.s1 = disp2isq_wrdata[104] && disp2isq_src1_busy && !byp(disp2isq_wrdata[116:111]);
        e.s2 = disp2isq_wrdata[103] && disp2isq_src2_busy && !byp(disp2isq_wrdata[110:105]);
        mq.push_back(e);
      end
    end
  end

  always @(negedge clock) begin
    int sel;
    if (live) begin
      sel = model_sel();
      check("model_count", 256'(isq_count), 256'(mq.size()));
      check("model_disp_ready", 256'(isq2disp_ready), 256'(mq.size() < DEPTH));
      check("model_exu_valid", 256'(isq2exu_valid), 256'(sel >= 0));
      if (sel >= 0) check("model_exu_data", 256'(isq2exu_data), 256'(mq[sel].p));
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [DATA_W-1:0] p, input bit b1, input bit b2);
    disp2isq_wren      = 1'b1;
    disp2isq_wrdata    = p;
    disp2isq_src1_busy = b1;
    disp2isq_src2_busy = b2;
    step();
    disp2isq_wren      = 1'b0;
    disp2isq_src1_busy = 1'b0;
    disp2isq_src2_busy = 1'b0;
  endtask

  initial begin
    reset_n            = 1'b0;
    flush              = 1'b0;
    disp2isq_wren      = 1'b0;
    disp2isq_wrdata    = '0;
    disp2isq_src1_busy = 1'b0;
    disp2isq_src2_busy = 1'b0;
    wb0_valid          = 1'b0;
    wb0_prd            = '0;
    wb1_valid          = 1'b0;
    wb1_prd            = '0;
    exu2isq_ready      = 1'b0;

    // Reset state
    step();
    step();
    reset_n = 1'b1;
    check("rst_count", 256'(isq_count), 256'(0));
    check("rst_disp_ready", 256'(isq2disp_ready), 256'(1));
    check("rst_exu_valid", 256'(isq2exu_valid), 256'(0));
    check("rst_exu_data", 256'(isq2exu_data), 256'(0));

    // Basic write then issue, one-cycle latency
    exu2isq_ready = 1'b1;
    wr(mk(0, 5, 6, 1, 1), 1'b0, 1'b0);
    check("t1_valid", 256'(isq2exu_valid), 256'(1));
    check("t1_data", 256'(isq2exu_data), 256'(mk(0, 5, 6, 1, 1)));
    check("t1_count", 256'(isq_count), 256'(1));
    step();
    check("t1_count_after", 256'(isq_count), 256'(0));

    // Sleeping source woken by wb1 two cycles later
    wr(mk(1, 9, 3, 1, 1), 1'b1, 1'b0);
    check("t2_asleep0", 256'(isq2exu_valid), 256'(0));
    step();
    check("t2_asleep1", 256'(isq2exu_valid), 256'(0));
    wb1_valid = 1'b1;
    wb1_prd   = 6'd9;
    #1;
    check("t2_wake_cycle", 256'(isq2exu_valid), 256'(0));
    step();
    wb1_valid = 1'b0;
    check("t2_valid", 256'(isq2exu_valid), 256'(1));
    check("t2_robid", 256'(robid_of(isq2exu_data)), 256'(1));
    step();
    check("t2_count", 256'(isq_count), 256'(0));

    // Non-register sources never sleep even when busy is reported
    wr(mk(30, 7, 8, 0, 0), 1'b1, 1'b1);
    check("nonreg_valid", 256'(isq2exu_valid), 256'(1));
    step();

    // Both wb ports wake both sources in the same cycle; a non-matching one does not
    wr(mk(40, 3, 4, 1, 1), 1'b1, 1'b1);
    wb0_valid = 1'b1;
    wb0_prd   = 6'd5;
    step();
    check("par_nomatch", 256'(isq2exu_valid), 256'(0));
    wb0_prd   = 6'd3;
    wb1_valid = 1'b1;
    wb1_prd   = 6'd4;
    step();
    wb0_valid = 1'b0;
    wb1_valid = 1'b0;
    check("par_valid", 256'(isq2exu_valid), 256'(1));
    check("par_robid", 256'(robid_of(isq2exu_data)), 256'(40));
    step();

    // Fill to capacity, ninth write ignored
    exu2isq_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) wr(mk(i, i + 10, i + 20, 1, 1), 1'b0, 1'b0);
    check("full_count", 256'(isq_count), 256'(8));
    check("full_disp_ready", 256'(isq2disp_ready), 256'(0));
    wr(mk(100, 1, 2, 1, 1), 1'b0, 1'b0);
    check("full_ignored", 256'(isq_count), 256'(8));
    check("full_oldest", 256'(robid_of(isq2exu_data)), 256'(0));

    // Full with issue and write together: no write, count 7
    exu2isq_ready = 1'b1;
    wr(mk(101, 1, 2, 1, 1), 1'b0, 1'b0);
    check("full_iss_count", 256'(isq_count), 256'(7));
    for (int i = 1; i < DEPTH; i++) begin
      check("order_robid", 256'(robid_of(isq2exu_data)), 256'(i));
      step();
    end
    check("drain_count", 256'(isq_count), 256'(0));

    // Age beats readiness order: older sleeper wins once woken
    exu2isq_ready = 1'b0;
    wr(mk(60, 20, 21, 1, 1), 1'b1, 1'b0);
    wr(mk(61, 22, 23, 1, 1), 1'b0, 1'b0);
    check("age_young_only", 256'(robid_of(isq2exu_data)), 256'(61));
    wb0_valid = 1'b1;
    wb0_prd   = 6'd20;
    step();
    wb0_valid = 1'b0;
    check("age_old_first", 256'(robid_of(isq2exu_data)), 256'(60));
    exu2isq_ready = 1'b1;
    step();
    check("age_then_young", 256'(robid_of(isq2exu_data)), 256'(61));
    step();

    // Flush with 4 entries and a concurrent write
    exu2isq_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(mk(70 + i, i, i, 1, 1), 1'b0, 1'b0);
    check("pre_flush_count", 256'(isq_count), 256'(4));
    flush = 1'b1;
    wr(mk(80, 1, 1, 1, 1), 1'b0, 1'b0);
    flush = 1'b0;
    check("flush_count", 256'(isq_count), 256'(0));
    check("flush_valid", 256'(isq2exu_valid), 256'(0));

    // Same-cycle wakeup at write time
    exu2isq_ready = 1'b1;
    wb0_valid     = 1'b1;
    wb0_prd       = 6'd12;
    wr(mk(50, 12, 13, 1, 1), 1'b1, 1'b0);
`ifdef ISQ_WAKEUP_BYPASS_EN
    check("bypass_valid", 256'(isq2exu_valid), 256'(1));
`else
    check("nobypass_asleep", 256'(isq2exu_valid), 256'(0));
`endif
    step();
    wb0_valid = 1'b0;
    step();
    step();
    check("bypass_drain", 256'(isq_count), 256'(0));

    // Reset mid-operation discards entries
    exu2isq_ready = 1'b0;
    wr(mk(90, 1, 2, 1, 1), 1'b0, 1'b0);
    wr(mk(91, 1, 2, 1, 1), 1'b0, 1'b0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("midrst_count", 256'(isq_count), 256'(0));
    check("midrst_valid", 256'(isq2exu_valid), 256'(0));
    check("midrst_data", 256'(isq2exu_data), 256'(0));
    check("midrst_ready", 256'(isq2disp_ready), 256'(1));
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/int_issue_queue.md
# int_issue_queue

Integer issue queue sitting directly downstream of dispatch. It accepts one renamed instruction per cycle together with its source busy status. It holds the instruction with per-source sleep bits until writeback wakeup clears them, then issues the oldest ready entry to the integer execute stage over a valid/ready handshake. Flush from redirect empties it.

## Interface
Parameters:
- DEPTH, 8, number of entries (power of two, ≥2)
- DATA_W, 248, dispatch payload width
- PREG_W, 6, physical register index width

Ports:
- clock  in  1  sole clock
- reset_n  in  1  synchronous, active-low reset
- flush  in  1  redirect; invalidates all entries
- disp2isq_wren  in  1  write request from dispatch
- disp2isq_wrdata  in  DATA_W  payload; prs1 [116:111], prs2 [110:105], src1_is_reg [104], src2_is_reg [103], robid [247:241]
- disp2isq_src1_busy  in  1  busy-table read for prs1
- disp2isq_src2_busy  in  1  busy-table read for prs2
- isq2disp_ready  out  1  queue can accept a write this cycle
- wb0_valid, wb1_valid  in  1  writeback wakeup strobes
- wb0_prd, wb1_prd  in  PREG_W  woken physical registers
- isq2exu_valid  out  1  selected entry ready to issue
- isq2exu_data  out  DATA_W  selected entry payload
- exu2isq_ready  in  1  execute accepts issue
- isq_count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Entry state: valid, payload, sleep1, sleep2, age vector.
- Write: takes effect on disp2isq_wren && isq2disp_ready. The lowest-index free entry is allocated.
  - sleep1 = src1_is_reg && disp2isq_src1_busy; sleep2 likewise for source 2.
  - Sources with is_reg=0 never sleep.
- isq2disp_ready = (count < DEPTH), computed from registered count. No write occurs when full, even if an issue happens in the same cycle.
- Wakeup: each cycle, for every valid entry and each wb port with valid high, a sleeping source whose prs equals wb_prd clears its sleep bit at the next edge. Both ports are evaluated in parallel.
- Ready entry: valid && !sleep1 && !sleep2.
- Select: the oldest ready entry by age matrix. isq2exu_valid = any ready entry; isq2exu_data = the selected payload (combinational from state).
- Issue: on isq2exu_valid && exu2isq_ready, the selected entry's valid clears at the edge.
- Write and issue in the same cycle: count unchanged. A freed slot is not reusable until the next cycle.
- Flush: all valid bits cleared at the edge and count set to 0. A write or issue in the same cycle is discarded. isq2exu_valid is still combinationally driven during the flush cycle; execute discards on flush.
- A new entry is younger than every existing valid entry.

## Timing
- Reset (reset_n=0 at an edge): all valid 0, count 0. isq2exu_valid 0, isq2disp_ready 1, isq2exu_data all zeros.
  - Reset mid-operation discards all entries.
- Write at edge N: the entry is visible from N+1. It can issue in cycle N+1 if not sleeping.
- Wakeup presented in cycle N clears sleep at edge N; the entry can issue in cycle N+1.
- Issue decision is combinational in the same cycle as the handshake. Minimum dispatch-to-issue latency is 1 cycle.

## Configuration
- ISQ_WAKEUP_BYPASS_EN defined: on write, a source is also not sleeping if its prs matches a same-cycle valid wb0_prd/wb1_prd. This closes the race with busy-table clear timing.
- Not defined: sleep bits come solely from disp2isq_src*_busy. The busy table must then provide write-through of same-cycle clears.

## Structure
- The shared package holds:
  - DEPTH and PREG_W defaults
  - payload bit-field offsets (PRS1_LSB, PRS2_LSB, SRC1_IS_REG_BIT, SRC2_IS_REG_BIT, ROBID_LSB)
  - DATA_W = 248
- One sub-module: isq_age_matrix.
  - DEPTH×DEPTH age bits, set row on allocate, clear column on free.
  - Outputs a one-hot oldest among a request vector.

## Test plan
- Reset, then write prs1=5, prs2=6, both not busy, exu2isq_ready=1 -> isq2exu_valid=1 the next cycle with the same payload; count returns 0 after issue.
- Write an entry with src1 busy on prs1=9; drive wb1_valid, wb1_prd=9 two cycles later -> isq2exu_valid rises exactly one cycle after the wakeup.
- Write 8 not-busy entries with exu2isq_ready=0 -> isq2disp_ready=0 and count=8. A 9th write is ignored. Then set ready=1 -> issue order follows write order (robid 0..7).
- Full queue with simultaneous issue and wren=1 -> no write accepted, count 7.
- Flush with 4 valid entries plus a concurrent write -> count=0, isq2exu_valid=0 the next cycle.
- With ISQ_WAKEUP_BYPASS_EN: write prs1=12 busy with wb0_valid, wb0_prd=12 in the same cycle -> issues the next cycle. Without the macro -> stays asleep.
